// File: rtl/sorted_result_serializer.sv
// Captures a sorted result vector in one handshake and streams it out one word
// per beat with index, last and duplicate-of-previous tags plus a distinct count.
module sorted_result_serializer #(
  parameter int NUMVALS = 16,
  parameter int SIZE    = 32,
  localparam int TOTAL  = 2 * NUMVALS,
  localparam int IDXW   = $clog2(2 * NUMVALS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [TOTAL*SIZE-1:0]   in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SIZE-1:0]         out_data,
  output logic [IDXW-1:0]         out_index,
  output logic                    out_last,
  output logic                    out_dup,
  output logic                    done,
  output logic [IDXW:0]           uniq_count
);

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(TOTAL - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t          state, state_next;
  logic [SIZE-1:0] buffer [TOTAL];
  logic [IDXW-1:0] idx;
  logic [IDXW-1:0] idx_prev;
  logic [IDXW:0]   uniq_run;
  logic [IDXW:0]   uniq_inc;
  logic            xfer;
  logic            last_xfer;
  logic            capture;

  // Outputs are gated by out_valid so that every out_* field reads zero outside a stream.
  always_comb begin
    idx_prev  = idx - 1'b1;
    out_valid = (state == STREAM);
    out_data  = out_valid ? buffer[idx] : '0;
    out_index = out_valid ? idx : '0;
    out_last  = out_valid && (idx == LAST_IDX);
    out_dup   = out_valid && (idx != '0) && (buffer[idx] == buffer[idx_prev]);
    xfer      = out_valid && out_ready;
    last_xfer = xfer && out_last;
    uniq_inc  = uniq_run + (out_dup ? (IDXW+1)'(0) : (IDXW+1)'(1));
  end

  // Capture is allowed while idle, or in the very beat the final word leaves.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    if (!rst) in_ready = (state == IDLE) || last_xfer;
    capture = in_valid && in_ready;
    case (state)
      IDLE:    if (capture) state_next = STREAM;
      STREAM:  if (last_xfer && !capture) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx        <= '0;
      uniq_run   <= '0;
      done       <= 1'b0;
      uniq_count <= '0;
    end else begin
      done <= last_xfer;
      if (last_xfer) uniq_count <= uniq_inc;
      if (capture) begin
        idx      <= '0;
        uniq_run <= '0;
      end else if (xfer) begin
        idx      <= out_last ? '0 : idx + 1'b1;
        uniq_run <= uniq_inc;
      end
    end
  end

  // The word buffer needs no reset: its contents are never visible outside a stream.
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int i = 0; i < TOTAL; i++) buffer[i] <= in_data[i*SIZE +: SIZE];
    end
  end

endmodule

// File: tb/tb_sorted_result_serializer.sv
// Directed bench for sorted_result_serializer: streams, stalls, back-to-back
// capture, mid-stream reset and ignored in_valid, checked with immediate assertions.
module tb_sorted_result_serializer;

  localparam int NUMVALS = 16;
  localparam int SIZE    = 32;
  localparam int TOTAL   = 2 * NUMVALS;
  localparam int IDXW    = $clog2(TOTAL);

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  in_valid;
  logic                  in_ready;
  logic [TOTAL*SIZE-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [SIZE-1:0]       out_data;
  logic [IDXW-1:0]       out_index;
  logic                  out_last;
  logic                  out_dup;
  logic                  done;
  logic [IDXW:0]         uniq_count;

  logic [SIZE-1:0] cur [TOTAL];
  logic [SIZE-1:0] nxt [TOTAL];
  int checks   = 0;
  int failures = 0;

  sorted_result_serializer #(.NUMVALS(NUMVALS), .SIZE(SIZE)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .out_last(out_last), .out_dup(out_dup),
    .done(done), .uniq_count(uniq_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pack_cur();
    for (int i = 0; i < TOTAL; i++) in_data[i*SIZE +: SIZE] = cur[i];
  endtask

  task automatic pack_nxt();
    for (int i = 0; i < TOTAL; i++) in_data[i*SIZE +: SIZE] = nxt[i];
  endtask

  // Presents cur for one cycle; on return index 0 should be visible.
  task automatic apply_stimulus();
    pack_cur();
    in_valid = 1'b1;
    #1;
    chk("cap_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Walks one stream of cur, checking every visible beat against the bench's own words.
  task automatic check_output(input int rmode, input bit b2b, input bit inj, input int exp_uniq);
    int  k = 0;
    int  cyc = 0;
    bit  xfer;
    bit  inj_done = 1'b0;
    while (k < TOTAL && cyc < 400) begin
      out_ready = (rmode == 0 || (b2b && k == TOTAL-1)) ? 1'b1 : ((cyc % 3) != 1);
      if (b2b && k >= TOTAL-3) begin
        in_valid = 1'b1;
        pack_nxt();
      end else if (inj && k == 5 && !inj_done) begin
        in_valid = 1'b1;
        in_data  = '1;
        inj_done = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      chk($sformatf("valid[%0d]", k), 64'(out_valid), 64'd1);
      chk($sformatf("data[%0d]", k), 64'(out_data), 64'(cur[k]));
      chk($sformatf("index[%0d]", k), 64'(out_index), 64'(k));
      chk($sformatf("last[%0d]", k), 64'(out_last), 64'(k == TOTAL-1));
      chk($sformatf("dup[%0d]", k), 64'(out_dup), 64'(k > 0 && cur[k] == cur[k-1]));
      if (in_valid) chk($sformatf("in_ready[%0d]", k), 64'(in_ready), 64'(k == TOTAL-1 && out_ready));
      xfer = out_ready;
      @(posedge clk); #1;
      cyc++;
      if (xfer) k++;
    end
    if (k < TOTAL) chk("stream_timeout", 64'(k), 64'(TOTAL));
    chk("done_pulse", 64'(done), 64'd1);
    chk("uniq_count", 64'(uniq_count), 64'(exp_uniq));
    if (b2b) begin
      in_valid = 1'b0;
      chk("b2b_valid", 64'(out_valid), 64'd1);
      chk("b2b_index", 64'(out_index), 64'd0);
      chk("b2b_data", 64'(out_data), 64'(nxt[0]));
    end else begin
      chk("end_valid", 64'(out_valid), 64'd0);
      chk("end_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      chk("done_cleared", 64'(done), 64'd0);
      chk("uniq_held", 64'(uniq_count), 64'(exp_uniq));
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    @(posedge clk); #1;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_index", 64'(out_index), 64'd0);
    chk("rst_flags", {62'd0, out_last, out_dup}, 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_uniq", 64'(uniq_count), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("idle_in_ready", 64'(in_ready), 64'd1);

    // Distinct ascending words 0..31, always ready.
    for (int i = 0; i < TOTAL; i++) cur[i] = SIZE'(i);
    apply_stimulus();
    check_output(0, 1'b0, 1'b0, 32);

    // All words equal.
    for (int i = 0; i < TOTAL; i++) cur[i] = 32'd7;
    apply_stimulus();
    check_output(0, 1'b0, 1'b0, 1);

    // [1,1,2,3,3,3,6,7,...] under periodic stalls: three distinct + 26 distinct.
    cur[0] = 1; cur[1] = 1; cur[2] = 2; cur[3] = 3; cur[4] = 3; cur[5] = 3;
    for (int i = 6; i < TOTAL; i++) cur[i] = SIZE'(i);
    apply_stimulus();
    check_output(1, 1'b0, 1'b0, 29);

    // Back-to-back: distinct multiples of 3 followed by an all-9 vector.
    for (int i = 0; i < TOTAL; i++) begin
      cur[i] = SIZE'(i * 3);
      nxt[i] = 32'd9;
    end
    apply_stimulus();
    check_output(0, 1'b1, 1'b0, 32);
    for (int i = 0; i < TOTAL; i++) cur[i] = nxt[i];
    check_output(0, 1'b0, 1'b0, 1);

    // In_valid pulse with all-ones data at index 5 must be ignored.
    for (int i = 0; i < TOTAL; i++) cur[i] = SIZE'(i + 100);
    apply_stimulus();
    check_output(0, 1'b0, 1'b1, 32);

    // Reset at index 10 abandons the stream without a done pulse.
    for (int i = 0; i < TOTAL; i++) cur[i] = SIZE'(i * 5);
    apply_stimulus();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
    end
    chk("pre_rst_index", 64'(out_index), 64'd10);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("post_rst_valid", 64'(out_valid), 64'd0);
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    chk("post_rst_done", 64'(done), 64'd0);
    chk("post_rst_uniq", 64'(uniq_count), 64'd0);
    for (int i = 0; i < TOTAL; i++) cur[i] = SIZE'(TOTAL - i);
    apply_stimulus();
    check_output(0, 1'b0, 1'b0, 32);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
